// File: rtl/seq_shifter_pkg.sv
// rtl/seq_shifter_pkg.sv - shared mode and FSM state types for the sequential shifter
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_stage.sv
// rtl/seq_shifter_shift_stage.sv - combinational one-position shift under a selected mode
module shift_stage
  import seq_shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] operand,
  input  logic [1:0]   mode,
  output logic [N-1:0] result,
  output logic         out_bit
);

  // Move the operand one position; out_bit is the bit leaving (or wrapping around) the word
  always_comb begin
    result  = operand;
    out_bit = 1'b0;
    case (mode_e'(mode))
      MODE_LSL: begin
        result  = {operand[N-2:0], 1'b0};
        out_bit = operand[N-1];
      end
      MODE_LSR: begin
        result  = {1'b0, operand[N-1:1]};
        out_bit = operand[0];
      end
      MODE_ASR: begin
        result  = {operand[N-1], operand[N-1:1]};
        out_bit = operand[0];
      end
      MODE_ROR: begin
        result  = {operand[0], operand[N-1:1]};
        out_bit = operand[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter, one position per clock, with busy/done handshake
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  data_in,
  input  logic [SW-1:0] amount,
  input  logic [1:0]    mode,
  output logic [N-1:0]  data_out,
  output logic          carry_out,
  output logic          busy,
  output logic          done
);

  state_e        state;
  state_e        state_nx;
  logic [SW-1:0] count;
  mode_e         mode_q;
  logic          accept;
  logic [N-1:0]  stage_result;
  logic          stage_bit;

  shift_stage #(.N(N)) u_stage (
    .operand (data_out),
    .mode    (mode_q),
    .result  (stage_result),
    .out_bit (stage_bit)
  );

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and status outputs; starts are only honoured outside SHIFT
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (amount != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (count == SW'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
        if (start) begin
          accept   = 1'b1;
          state_nx = (amount != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Working register, carry, counter and latched mode; all hold outside capture and SHIFT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      count     <= '0;
      mode_q    <= MODE_LSL;
    end else if (accept) begin
      data_out  <= data_in;
      carry_out <= 1'b0;
      count     <= amount;
      mode_q    <= mode_e'(mode);
    end else if (state == ST_SHIFT) begin
      data_out  <= stage_result;
      carry_out <= stage_bit;
      count     <= count - SW'(1);
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - randomized self-checking bench for seq_shifter against an arithmetic model
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] amount;
  logic [1:0] mode;
  logic [7:0] data_out;
  logic       carry_out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shifter #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .amount    (amount),
    .mode      (mode),
    .data_out  (data_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-word result of shifting d by k positions, using plain shift operators
  function automatic void model(input logic [7:0] d, input int k, input logic [1:0] m,
                                output logic [7:0] r, output logic c);
    r = d;
    c = 1'b0;
    if (k == 0) return;
    case (m)
      2'b00: begin r = d << k;                      c = d[8-k]; end
      2'b01: begin r = d >> k;                      c = d[k-1]; end
      2'b10: begin r = 8'($signed(d) >>> k);        c = d[k-1]; end
      default: begin r = (d >> k) | (d << (8 - k)); c = d[k-1]; end
    endcase
  endfunction

  task automatic accept_op(input logic [7:0] d, input logic [2:0] k, input logic [1:0] m);
    @(negedge clk);
    start = 1'b1; data_in = d; amount = k; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge t0. Checks timing and result; optionally
  // pokes an ignored start at t0+2 and optionally chains a new start in the DONE cycle.
  task automatic run_op(input logic [7:0] d, input logic [2:0] k, input logic [1:0] m,
                        input bit poke, input bit chain,
                        input logic [7:0] nd, input logic [2:0] nk, input logic [1:0] nm);
    logic [7:0] er;
    logic       ec;
    int         busy_cnt;
    int         early_done;
    model(d, int'(k), m, er, ec);
    busy_cnt   = 0;
    early_done = 0;
    for (int c = 0; c < int'(k); c++) begin
      data_in = 8'($urandom); amount = 3'($urandom_range(0, 7)); mode = 2'($urandom_range(0, 3));
      if (poke && c == 1) begin
        start = 1'b1; data_in = 8'h00;
      end
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) early_done++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    check("data_out", data_out, er);
    check("carry_out", carry_out, ec);
    check("busy_cycles", busy_cnt, int'(k));
    check("early_done", early_done, 0);
    if (chain) begin
      start = 1'b1; data_in = nd; amount = nk; mode = nm;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_done", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_hold_data", data_out, er);
      check("idle_hold_carry", carry_out, ec);
    end
  endtask

  initial begin
    logic [7:0] d, nd;
    logic [2:0] k, nk;
    logic [1:0] m, nm;
    bit         chained, ch, pk;
    int         done_seen;

    rst = 1'b1; start = 1'b0; data_in = '0; amount = '0; mode = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_carry", carry_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    accept_op(8'h81, 3'd1, 2'b00); run_op(8'h81, 3'd1, 2'b00, 0, 0, 0, 0, 0);
    check("lsl_dir", data_out, 8'h02);
    accept_op(8'h80, 3'd3, 2'b10); run_op(8'h80, 3'd3, 2'b10, 0, 0, 0, 0, 0);
    check("asr_dir", data_out, 8'hF0);
    accept_op(8'h01, 3'd1, 2'b11); run_op(8'h01, 3'd1, 2'b11, 0, 0, 0, 0, 0);
    check("ror_dir", data_out, 8'h80);
    accept_op(8'hFF, 3'd7, 2'b01); run_op(8'hFF, 3'd7, 2'b01, 0, 0, 0, 0, 0);
    check("lsr_dir", {carry_out, data_out}, 9'h101);
    accept_op(8'h5A, 3'd0, 2'b00); run_op(8'h5A, 3'd0, 2'b00, 0, 0, 0, 0, 0);
    check("zero_dir", data_out, 8'h5A);
    accept_op(8'h0F, 3'd4, 2'b00); run_op(8'h0F, 3'd4, 2'b00, 1, 0, 0, 0, 0);
    check("ignored_start", data_out, 8'hF0);

    accept_op(8'h3C, 3'd2, 2'b11);
    run_op(8'h3C, 3'd2, 2'b11, 0, 1, 8'hA5, 3'd3, 2'b01);
    run_op(8'hA5, 3'd3, 2'b01, 0, 0, 0, 0, 0);
    check("b2b_dir", data_out, 8'h14);

    accept_op(8'hFF, 3'd5, 2'b00);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_data", data_out, 8'h00);
    check("midrst_carry", carry_out, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    rst = 1'b0; start = 1'b1; data_in = 8'h01; amount = 3'd1; mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) check("rst_no_done", done_seen, 0);
    end
    run_op(8'h01, 3'd1, 2'b00, 0, 0, 0, 0, 0);
    check("post_rst_lsl", data_out, 8'h02);

    chained = 0;
    d = '0; k = '0; m = '0;
    for (int i = 0; i < 60; i++) begin
      if (!chained) begin
        d = 8'($urandom); k = 3'($urandom_range(0, 7)); m = 2'($urandom_range(0, 3));
        accept_op(d, k, m);
      end
      nd = 8'($urandom); nk = 3'($urandom_range(0, 7)); nm = 2'($urandom_range(0, 3));
      ch = ($urandom_range(0, 3) == 0) && (i < 59);
      pk = (k >= 3'd3) && ($urandom_range(0, 1) == 1);
      run_op(d, k, m, pk, ch, nd, nk, nm);
      chained = ch;
      if (ch) begin
        d = nd; k = nk; m = nm;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter N, default 8: data width in bits, legal range N >= 2.
REQ-002 Parameter SW, default $clog2(N): width of the shift-amount port.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-006 data_in  input  N  operand, captured when a start is accepted.
REQ-007 amount  input  SW  shift distance, 0..N-1, captured when a start is accepted.
REQ-008 mode  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-009 data_out  output  N  working register, which also holds the final result.
REQ-010 carry_out  output  1  last bit shifted out; for ROR, the last bit wrapped.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when data_out and carry_out are final.

Function
REQ-013 The block SHALL implement an FSM with the states IDLE, SHIFT and DONE.
REQ-014 A start seen in IDLE or DONE SHALL be accepted; on that edge, data_out <= data_in, the counter <= amount, mode is latched and carry_out <= 0.
REQ-015 On acceptance, the next state SHALL be SHIFT if amount != 0, and DONE if amount == 0.
REQ-016 Each edge spent in SHIFT SHALL move data_out one position under the latched mode and decrement the counter.
REQ-017 On the edge where the counter goes from 1 to 0, the next state SHALL be DONE.
REQ-018 Latency: for an accepted start on edge t0 with amount k, done SHALL be high in the cycle after edge t0+k (k=0 means the cycle after t0).
REQ-019 LSL SHALL shift in 0 at bit 0, and carry_out SHALL take the old bit N-1.
REQ-020 LSR SHALL shift in 0 at bit N-1, and carry_out SHALL take the old bit 0.
REQ-021 ASR SHALL replicate bit N-1 into bit N-1, and carry_out SHALL take the old bit 0.
REQ-022 ROR SHALL move the old bit 0 into bit N-1, and carry_out SHALL take that same bit.
REQ-023 busy SHALL be high exactly in SHIFT; done SHALL be high exactly in DONE.
REQ-024 DONE SHALL last one cycle, then go to IDLE, unless a new start is accepted in DONE.
REQ-025 A start while in SHIFT SHALL be ignored: no capture, no effect on the current operation.
REQ-026 data_out and carry_out SHALL hold their values in IDLE until the next accepted start.
REQ-027 The latched mode and amount SHALL be unaffected by changes on the mode, amount or data_in inputs during SHIFT.

Reset
REQ-028 While rst is high, the state SHALL be IDLE, and data_out, the counter, carry_out, busy and done SHALL all be 0.
REQ-029 If rst is asserted mid-operation, the operation SHALL be abandoned with no done pulse, and the block SHALL accept start on the first edge after rst deasserts.

Structure
REQ-030 Package seq_shifter_pkg SHALL hold the mode enum (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR) and the FSM state enum.
REQ-031 One-position shifting SHALL be a combinational sub-module, shift_stage, parameterised on N.
REQ-032 shift_stage inputs SHALL be operand and mode; its outputs SHALL be the shifted value and the out-bit.
REQ-033 seq_shifter SHALL contain only the FSM, the counter and the registers.

Verification (N=8)
REQ-034 LSL test: data_in 0x81, amount 1 -> cycle after t0+1: data_out 0x02, carry_out 1, done 1, and busy high for 1 cycle.
REQ-035 ASR test: data_in 0x80, amount 3 -> done after t0+3: data_out 0xF0, carry_out 0.
REQ-036 ROR and LSR tests: ROR 0x01 by 1 -> 0x80, carry_out 1; LSR 0xFF by 7 -> 0x01, carry_out 1, and busy high for 7 cycles.
REQ-037 Zero-shift test: amount 0, data_in 0x5A -> done in the cycle after t0, data_out 0x5A, carry_out 0, busy never high.
REQ-038 Ignored-start test: a start with 0x00 at t0+2 during an LSL 0x0F by 4 -> result still 0xF0, carry_out 0, done after t0+4.
REQ-039 Back-to-back test: a start held high in DONE is accepted, and its new operation completes with correct timing.
REQ-040 Reset test: rst pulsed at t0+2 of a 5-step shift -> all outputs 0, no done pulse, and a fresh LSL 0x01 by 1 then gives 0x02.
